// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style main controller: Moore FSM sequencing fetch/decode/execute steps.
// Latency: outputs are a pure decode of the state register; one state per clock edge.
// Backpressure: none; the FSM advances every cycle and never stalls.
//
// Ports:
//   clk, rst_n      - system clock, asynchronous active-low reset (forces FETCH)
//   Op              - opcode from the instruction register (next-state only)
//   PCWrite/Branch  - unconditional / Zero-qualified PC write enables
//   PCSrc           - 00 PC+4, 01 branch target, 10 jump target
//   IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA - datapath strobes/selects
//   ALUSrcB         - 00 reg B, 01 const 4, 10 sext imm, 11 sext imm<<2
//   ALUOp           - 00 add, 01 subtract, 10 decode funct
//   State           - current state code, exported for debug
module multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  output logic       PCWrite,
  output logic       Branch,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Op is consulted only in DECODE and MEMADR; the IR
  // holds it stable for the whole instruction, so re-sampling is safe.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        if (Op == OP_LW || Op == OP_SW) state_d = S_MEMADR;
        else if (Op == OP_RTYPE)        state_d = S_EXECUTE;
        else if (Op == OP_BEQ)          state_d = S_BRANCH;
        else if (Op == OP_ADDI)         state_d = S_ADDIEX;
        else if (Op == OP_J)            state_d = S_JUMP;
        else                            state_d = S_FETCH; // unknown opcode: skip, no side effects
      end
      S_MEMADR: begin
        if (Op == OP_SW) state_d = S_MEMWR;
        else             state_d = S_MEMRD;
      end
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      // Terminal states and unreachable codes 12-15 all return to FETCH.
      default:   state_d = S_FETCH;
    endcase
  end

  // Moore output decode; unreachable codes leave every output at 0.
  always_comb begin
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    PCSrc    = 2'b00;
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
      end
      S_DECODE: begin
        // Precompute branch target while the register file is read.
        ALUSrcB = 2'b11;
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        IorD = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        Branch  = 1'b1;
        PCSrc   = 2'b01;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b10;
      end
      default: ;
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed + random opcode streams against an instruction-level model.
// Latency: checks sample at the falling edge, half a cycle after each state change.
// Backpressure: not applicable.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       pc_write, branch, iord, mem_write, ir_write, reg_dst, memto_reg, reg_write, alu_src_a;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;

  multicycle_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Op       (op),
    .PCWrite  (pc_write),
    .Branch   (branch),
    .PCSrc    (pc_src),
    .IorD     (iord),
    .MemWrite (mem_write),
    .IRWrite  (ir_write),
    .RegDst   (reg_dst),
    .MemtoReg (memto_reg),
    .RegWrite (reg_write),
    .ALUSrcA  (alu_src_a),
    .ALUSrcB  (alu_src_b),
    .ALUOp    (alu_op),
    .State    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector packing:
  // {PCWrite, Branch, PCSrc[1:0], IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0]}
  logic [14:0] outs;
  assign outs = {pc_write, branch, pc_src, iord, mem_write, ir_write, reg_dst,
                 memto_reg, reg_write, alu_src_a, alu_src_b, alu_op};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected output vector for each named step of the instruction.
  function automatic logic [14:0] exp_outs(input int s);
    logic [14:0] v;
    v = '0;
    case (s)
      0:  begin v[8] = 1'b1; v[14] = 1'b1; v[3:2] = 2'b01; end      // IRWrite, PCWrite, ALUSrcB=01
      1:  v[3:2] = 2'b11;
      2, 9: begin v[4] = 1'b1; v[3:2] = 2'b10; end                  // ALUSrcA, ALUSrcB=10
      3:  v[10] = 1'b1;                                             // IorD
      4:  begin v[6] = 1'b1; v[5] = 1'b1; end                       // MemtoReg, RegWrite
      5:  begin v[10] = 1'b1; v[9] = 1'b1; end                      // IorD, MemWrite
      6:  begin v[4] = 1'b1; v[1:0] = 2'b10; end
      7:  begin v[7] = 1'b1; v[5] = 1'b1; end                       // RegDst, RegWrite
      10: v[5] = 1'b1;
      8:  begin v[4] = 1'b1; v[1:0] = 2'b01; v[13] = 1'b1; v[12:11] = 2'b01; end
      11: begin v[14] = 1'b1; v[12:11] = 2'b10; end
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic bit is_known(input logic [5:0] o);
    return (o == OP_RTYPE) || (o == OP_LW) || (o == OP_SW) ||
           (o == OP_BEQ) || (o == OP_ADDI) || (o == OP_J);
  endfunction

  // Instruction-level model: the full sequence of states visited by one opcode.
  function automatic void path_of(input logic [5:0] o, output int p[$]);
    p = {};
    if      (o == OP_LW)    p = '{0, 1, 2, 3, 4};
    else if (o == OP_SW)    p = '{0, 1, 2, 5};
    else if (o == OP_RTYPE) p = '{0, 1, 6, 7};
    else if (o == OP_ADDI)  p = '{0, 1, 9, 10};
    else if (o == OP_BEQ)   p = '{0, 1, 8};
    else if (o == OP_J)     p = '{0, 1, 11};
    else                    p = '{0, 1};
  endfunction

  // Expected cycle count per opcode, stated independently of the path table.
  function automatic int latency_of(input logic [5:0] o);
    if (o == OP_LW) return 5;
    if (o == OP_SW || o == OP_RTYPE || o == OP_ADDI) return 4;
    if (o == OP_BEQ || o == OP_J) return 3;
    return 2;
  endfunction

  // Run one instruction; called at a falling edge with the DUT in FETCH.
  task automatic run_instr(input logic [5:0] o);
    int p[$];
    int cycles;
    path_of(o, p);
    op = o;
    cycles = 0;
    foreach (p[k]) begin
      check($sformatf("state op=%0h step%0d", o, k), 32'(state), 32'(p[k]));
      check($sformatf("outs op=%0h st=%0d", o, p[k]), 32'(outs), 32'(exp_outs(p[k])));
      check("pcwrite&branch", 32'(pc_write & branch), 32'd0);
      check("memwrite&regwrite", 32'(mem_write & reg_write), 32'd0);
      @(posedge clk);
      @(negedge clk);
      cycles++;
      if (state == 4'd0) break;
    end
    check($sformatf("latency op=%0h", o), 32'(cycles), 32'(latency_of(o)));
    check($sformatf("back to fetch op=%0h", o), 32'(state), 32'd0);
  endtask

  initial begin
    logic [5:0] dir_ops [7];
    logic [5:0] ro;
    int         sel;

    dir_ops = '{OP_LW, OP_SW, OP_BEQ, OP_J, OP_RTYPE, OP_ADDI, 6'b111111};

    rst_n = 1'b0;
    op    = OP_LW;
    #2;
    check("reset state", 32'(state), 32'd0);
    check("reset outs", 32'(outs), 32'(exp_outs(0)));
    @(posedge clk);
    #1;
    check("reset held across edge", 32'(state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (dir_ops[i]) run_instr(dir_ops[i]);

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0: ro = OP_RTYPE;
        1: ro = OP_LW;
        2: ro = OP_SW;
        3: ro = OP_BEQ;
        4: ro = OP_ADDI;
        5: ro = OP_J;
        default: begin
          ro = 6'($urandom_range(0, 63));
          for (int t = 0; t < 8 && is_known(ro); t++) ro = 6'($urandom_range(0, 63));
          if (is_known(ro)) ro = 6'b111110;
        end
      endcase
      run_instr(ro);
    end

    // Abort a load mid-flight: reset during MEMRD must force FETCH without an edge.
    op = OP_LW;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("abort reached memrd", 32'(state), 32'd3);
    rst_n = 1'b0;
    #1;
    check("async reset state", 32'(state), 32'd0);
    check("async reset outs", 32'(outs), 32'(exp_outs(0)));
    @(posedge clk);
    #1;
    check("reset hold state", 32'(state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first edge after reset", 32'(state), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
